// File: rtl/shift_pkg.sv
// Shared types for the shift mask/fill stage: op encoding, FIFO occupancy
// states and the buffered entry layout.
package shift_pkg;

  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    OP_ROT = 2'd0,
    OP_SLL = 2'd1,
    OP_SRL = 2'd2,
    OP_SRA = 2'd3
  } shift_op_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Sized for the default width; narrower instances use the low DATA_W bits.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] result;
    logic                  zero;
  } fifo_entry_t;

endpackage

// File: rtl/shift_mask_gen.sv
// Combinational mask/fill applied to an already-rotated operand; turns a
// rotate into a logical or arithmetic shift.
module shift_mask_gen
  import shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0]  rot,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  input  logic               sign,
  output logic [DATA_W-1:0]  result,
  output logic               zero
);

  localparam logic [DATA_W-1:0] ALL_ONES = '1;

  logic [DATA_W-1:0] mask_l;
  logic [DATA_W-1:0] mask_r;

  always_comb begin
    mask_l = ALL_ONES << shamt;
    mask_r = ALL_ONES >> shamt;
    result = rot;
    case (shift_op_e'(op))
      OP_ROT:  result = rot;
      OP_SLL:  result = rot & mask_l;
      OP_SRL:  result = rot & mask_r;
      // Bits vacated by the right shift are exactly the ones cleared by mask_r.
      OP_SRA:  result = (rot & mask_r) | ({DATA_W{sign}} & ~mask_r);
      default: result = rot;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/shift_mask_stage.sv
// Shift mask/fill stage with a 2-entry output FIFO and registered in_ready.
// Optional pop counter enabled by defining SHIFT_MASK_STATS_EN.
module shift_mask_stage
  import shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_rot,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic               in_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_zero
`ifdef SHIFT_MASK_STATS_EN
  ,
  output logic [31:0]        stat_count
`endif
);

  logic [DATA_W-1:0] gen_result;
  logic              gen_zero;

  shift_mask_gen #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_mask_gen (
    .rot    (in_rot),
    .shamt  (in_shamt),
    .op     (in_op),
    .sign   (in_sign),
    .result (gen_result),
    .zero   (gen_zero)
  );

  occ_e        occ_q, occ_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  fifo_entry_t mem_q [2];
  fifo_entry_t mem_d [2];
  fifo_entry_t wr_entry;
  logic        push;
  logic        pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    wr_entry                    = '0;
    wr_entry.result[DATA_W-1:0] = gen_result;
    wr_entry.zero               = gen_zero;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // push+pop leaves occupancy unchanged; push is never taken when FULL
    // and pop is never taken when EMPTY.
    case ({push, pop})
      2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_d = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: occ_d = occ_q;
    endcase

    in_ready_d  = (occ_d != OCC_FULL);
    out_valid_d = (occ_d != OCC_EMPTY);
  end

  // Control state: asynchronous reset discards anything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= OCC_EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // FIFO storage: contents are meaningless unless out_valid marks them live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_valid_q ? mem_q[rd_ptr_q].result[DATA_W-1:0] : '0;
  assign out_zero   = out_valid_q ? mem_q[rd_ptr_q].zero : 1'b1;

`ifdef SHIFT_MASK_STATS_EN
  logic [31:0] stat_count_q, stat_count_d;

  always_comb begin
    stat_count_d = stat_count_q;
    if (pop && (stat_count_q != 32'hFFFF_FFFF)) begin
      stat_count_d = stat_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count_q <= 32'd0;
    end else begin
      stat_count_q <= stat_count_d;
    end
  end

  assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_shift_mask_stage.sv
// Self-checking bench for shift_mask_stage: directed cases plus randomized
// traffic against a shift-level reference model and FIFO queue.
module tb_shift_mask_stage;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_rot;
  logic [5:0]   in_shamt;
  logic [1:0]   in_op;
  logic         in_sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zero;
`ifdef SHIFT_MASK_STATS_EN
  logic [31:0]  stat_count;
`endif

  int total = 0;
  int bad   = 0;

  shift_mask_stage #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rot     (in_rot),
    .in_shamt   (in_shamt),
    .in_op      (in_op),
    .in_sign    (in_sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero)
`ifdef SHIFT_MASK_STATS_EN
    ,
    .stat_count (stat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int k);
    int kk;
    kk = k % W;
    if (kk == 0) return x;
    return (x << kk) | (x >> (W - kk));
  endfunction

  // Reference: the shift the op asks for, computed directly on the source.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] src, input int op, input int n);
    logic signed [W-1:0] s;
    s = src;
    case (op)
      0:       return rotl(src, n);
      1:       return src << n;
      2:       return src >> n;
      default: return s >>> n;
    endcase
  endfunction

  // Upstream rotator behaviour feeding the stage.
  task automatic drive(input logic [W-1:0] src, input int op, input int n);
    in_op    = 2'(op);
    in_shamt = 6'(n);
    in_sign  = src[W-1];
    in_rot   = (op >= 2) ? rotl(src, (W - n) % W) : rotl(src, n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rot = '0; in_shamt = '0; in_op = '0; in_sign = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("FAIL reset_out_result: got %h want 0", out_result); end
    total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL reset_out_zero: got %b want 1", out_zero); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef SHIFT_MASK_STATS_EN
    total++; if (stat_count !== 32'd0) begin bad++; $display("FAIL reset_stat: got %0d want 0", stat_count); end
`endif
  endtask

  task automatic test_sll_example;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd1; in_shamt = 6'd4; in_rot = 64'h0000_0000_0000_00F0; in_sign = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sll_latency: out_valid got %b want 1", out_valid); end
    total++; if (out_result !== 64'h0000_0000_0000_00F0) begin bad++; $display("FAIL sll_result: got %h want 00000000000000f0", out_result); end
    total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL sll_zero: got %b want 0", out_zero); end
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sll_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_sra_example;
    logic [W-1:0] exp_v;
    exp_v = ref_shift(64'h8000_0000_0000_0000, 3, 4);
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd3; in_shamt = 6'd4; in_rot = 64'h0800_0000_0000_0000; in_sign = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_result !== 64'hF800_0000_0000_0000) begin bad++; $display("FAIL sra_example: got %h want f800000000000000", out_result); end
    total++; if (out_result !== exp_v) begin bad++; $display("FAIL sra_model: got %h want %h", out_result, exp_v); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_srl_boundary;
    in_valid = 1'b1; in_op = 2'd2; in_shamt = 6'd63; in_rot = 64'hF; in_sign = 1'b0;
    @(negedge clk);
    total++; if (out_result !== 64'd1) begin bad++; $display("FAIL srl_n63: got %h want 1", out_result); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL srl_ready_one: got %b want 1", in_ready); end
    in_shamt = 6'd0; in_rot = '0;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL srl_ready_full: got %b want 0", in_ready); end
    total++; if (out_result !== 64'd1) begin bad++; $display("FAIL srl_head_hold: got %h want 1", out_result); end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_result !== '0) begin
      bad++; $display("FAIL srl_n0_zero: valid=%b zero=%b result=%h want 1 1 0", out_valid, out_zero, out_result);
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL srl_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] src [3];
    int           ops [3];
    int           ns  [3];
    logic [W-1:0] got [$];
    logic         pushed_c;
    for (int i = 0; i < 3; i++) begin
      src[i] = {$urandom, $urandom}; ops[i] = $urandom_range(0, 3); ns[i] = $urandom_range(0, 63);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; drive(src[0], ops[0], ns[0]);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_1: got %b want 1", in_ready); end
    drive(src[1], ops[1], ns[1]);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_after_2: got %b want 0", in_ready); end
    drive(src[2], ops[2], ns[2]);
    repeat (2) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || out_result !== ref_shift(src[0], ops[0], ns[0])) begin
        bad++; $display("FAIL b2b_hold: in_ready=%b head=%h want 0 %h", in_ready, out_result, ref_shift(src[0], ops[0], ns[0]));
      end
    end
    out_ready = 1'b1;
    pushed_c = 1'b0;
    for (int cyc = 0; cyc < 20 && got.size() < 3; cyc++) begin
      if (out_valid && out_ready) got.push_back(out_result);
      if (in_valid && in_ready) pushed_c = 1'b1;
      @(negedge clk);
      if (pushed_c) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++; if (got.size() != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      total++; if (got[i] !== ref_shift(src[i], ops[i], ns[i])) begin
        bad++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i], ref_shift(src[i], ops[i], ns[i]));
      end
    end
  endtask

  task automatic test_push_pop_one;
    logic [W-1:0] xs [6];
    for (int i = 0; i < 6; i++) xs[i] = {$urandom, $urandom};
    out_ready = 1'b0;
    in_valid = 1'b1; drive(xs[0], 0, 0);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== xs[i]) begin
        bad++; $display("FAIL pushpop_one[%0d]: valid=%b ready=%b head=%h want 1 1 %h", i, out_valid, in_ready, out_result, xs[i]);
      end
      drive(xs[i+1], 0, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (out_result !== xs[5]) begin bad++; $display("FAIL pushpop_last: got %h want %h", out_result, xs[5]); end
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pushpop_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_random;
    logic [W-1:0] q [$];
    logic [W-1:0] src;
    int           op, n, pops;
    logic         v, r, push, pop;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pops = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, out_valid, q.size() != 0); end
      total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        total++; if (out_result !== q[0] || out_zero !== (q[0] == '0)) begin
          bad++; $display("FAIL rand_data@%0d: got %h/%b want %h/%b", cyc, out_result, out_zero, q[0], q[0] == '0);
        end
      end
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 2) != 0);
      src = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom};
      op  = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       n = 0;
        1:       n = W - 1;
        default: n = $urandom_range(0, W - 1);
      endcase
      drive(src, op, n);
      in_valid = v; out_ready = r;
      push = v && (q.size() < 2);
      pop  = r && (q.size() > 0);
      @(negedge clk);
      if (pop) begin void'(q.pop_front()); pops++; end
      if (push) q.push_back(ref_shift(src, op, n));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    while (q.size() > 0) begin
      total++; if (out_result !== q[0]) begin bad++; $display("FAIL rand_drain: got %h want %h", out_result, q[0]); end
      @(negedge clk);
      void'(q.pop_front()); pops++;
    end
    out_ready = 1'b0;
`ifdef SHIFT_MASK_STATS_EN
    total++; if (stat_count !== 32'(pops)) begin bad++; $display("FAIL rand_stat: got %0d want %0d", stat_count, pops); end
`endif
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_full;
    out_ready = 1'b0;
    in_valid = 1'b1; drive({$urandom, $urandom}, 1, 3);
    @(negedge clk);
    drive({$urandom, $urandom}, 2, 5);
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL rstfull_pre: ready=%b valid=%b want 0 1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_result !== '0 || out_zero !== 1'b1) begin
      bad++; $display("FAIL rstfull_async: valid=%b result=%h zero=%b want 0 0 1", out_valid, out_result, out_zero);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rstfull_post: ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
`ifdef SHIFT_MASK_STATS_EN
    total++; if (stat_count !== 32'd0) begin bad++; $display("FAIL rstfull_stat: got %0d want 0", stat_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_sll_example();
    test_sra_example();
    test_srl_boundary();
    test_back_to_back();
    test_push_pop_one();
    test_random();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_mask_stage.md
SHIFT_MASK_STAGE -- requirements
Module: shift_mask_stage

Interface
- REQ-001: Parameter DATA_W, default 64: datapath width; SHALL be a power of two, at least 8.
- REQ-002: Parameter SHAMT_W, default $clog2(DATA_W): shift-amount width; SHALL NOT be overridden independently of DATA_W.
- REQ-003: clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: in_valid  input  1  upstream rotator result valid.
- REQ-006: in_ready  output  1  stage can accept; SHALL be driven from a register only.
- REQ-007: in_rot  input  DATA_W  rotate-left output of the upstream rotator.
- REQ-008: in_shamt  input  SHAMT_W  original shift amount n requested by the op.
- REQ-009: in_op  input  2  shift_op_e: ROT=0, SLL=1, SRL=2, SRA=3.
- REQ-010: in_sign  input  1  MSB of the unrotated source operand, used by SRA.
- REQ-011: out_valid  output  1  result available at FIFO head.
- REQ-012: out_ready  input  1  downstream accepts.
- REQ-013: out_result  output  DATA_W  final shifted result.
- REQ-014: out_zero  output  1  asserted when out_result is all zeros.

Function
- REQ-015: Upstream SHALL present rotate-left by n for ROT/SLL and rotate-left by (DATA_W-n) mod DATA_W for SRL/SRA; this stage SHALL only mask and fill.
- REQ-016: ROT SHALL output in_rot unchanged.
- REQ-017: SLL SHALL output in_rot AND (all-ones << n).
- REQ-018: SRL SHALL output in_rot AND (all-ones >> n).
- REQ-019: SRA SHALL output the SRL value with the top n bits replaced by in_sign.
- REQ-020: n=0 SHALL give in_rot for every op; n=DATA_W-1 SHALL keep exactly one source bit.
- REQ-021: A transfer occurs when in_valid and in_ready are both high; the masked result and zero flag SHALL be written into a 2-entry FIFO on that edge.
- REQ-022: Latency SHALL be one cycle: a result accepted at edge k SHALL appear with out_valid at edge k when the FIFO was empty.
- REQ-023: FIFO occupancy states EMPTY (0), ONE (1), FULL (2); push-only increments, pop-only decrements, push+pop in ONE stays ONE.
- REQ-024: in_ready SHALL equal (next occupancy < 2), so no push is ever accepted while FULL and no data is dropped.
- REQ-025: out_result and out_zero SHALL hold stable while out_valid is high and out_ready is low.
- REQ-026: Order SHALL be preserved; read/write pointers wrap modulo 2.

Reset
- REQ-027: On rst_n low: occupancy=0, pointers=0, out_valid=0, in_ready=1 after deassert; out_result=0, out_zero=1.
- REQ-028: Reset mid-transfer SHALL discard all buffered entries; no partial result SHALL be emitted.

Configuration
- REQ-029: Macro SHIFT_MASK_STATS_EN defined: add output stat_count [31:0], incremented on each pop, saturating at 0xFFFF_FFFF, reset to 0.
- REQ-030: Macro undefined: no stat_count port and no counter logic.

Structure
- REQ-031: Package shift_pkg SHALL hold shift_op_e, DATA_W default, and the FIFO entry struct {result, zero}.
- REQ-032: Mask/fill logic SHALL be a combinational sub-module shift_mask_gen; FIFO control stays in the top.

Verification
- REQ-033: SLL, in_rot=0x0000_0000_0000_00F0, n=4 -> out_result=0x...00F0, out_zero=0, out_valid one cycle later.
- REQ-034: SRA, source 0x8000_0000_0000_0000, n=4, in_rot=0x0800_0000_0000_0000, in_sign=1 -> 0xF800_0000_0000_0000.
- REQ-035: out_ready=0, three back-to-back pushes -> in_ready low after second push, third held, all three delivered in order once out_ready=1.
- REQ-036: Occupancy ONE, simultaneous push and pop -> occupancy stays ONE, in_ready stays 1, no bubble.
- REQ-037: SRL, in_rot=0x0000_0000_0000_000F, n=63 -> out_result=1; n=0 with in_rot=0 -> out_zero=1.
- REQ-038: rst_n pulsed low while FULL -> out_valid=0 immediately, in_ready=1 after release, stat_count=0 when enabled.
